dac_cmd_scheduler: RTL and testbench

//  Shares the single MCP4725 DAC interface between two requesters (port 0: waveform/stream

---
 rtl/dac_cmd_scheduler.sv | 177 +++++++++++++++++
 tb/tb_dac_cmd_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_cmd_scheduler.sv
// dac_cmd_scheduler: shares one MCP4725 DAC interface between a stream
// requester (port 0) and a config requester (port 1). Round-robin arbitration,
// command latching, start strobe generation, busy tracking with a timeout, and
// a one-cycle completion ack back to the winning requester.
// Build option: define DAC_RATE_LIMIT_EN to insert a GAP state that holds
// GAP_CYCLES idle cycles after every completion before re-arbitrating.
`timescale 1ns/1ps
module dac_cmd_scheduler #(
  parameter int DATA_W     = 12,
  parameter int BUSY_TMO   = 255,
  parameter int GAP_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [DATA_W-1:0] val0,
  input  logic [1:0]        mode0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] val1,
  input  logic [1:0]        mode1,
  input  logic              mem1,
  output logic              ack1,
  output logic [DATA_W-1:0] dac_val,
  output logic [1:0]        dac_mode,
  output logic              dac_upd,
  output logic              dac_mem_wr,
  input  logic              dac_busy,
  output logic              grant,
  output logic              err,
  output logic [DATA_W-1:0] cur_val
);

  // The busy timer only ever holds 0 .. BUSY_TMO-1; the final count fires the timeout.
  localparam int TMR_W = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(BUSY_TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

`ifdef DAC_RATE_LIMIT_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  // Every completion (normal or timeout) rests in GAP before the next grant.
  localparam state_t S_POST = S_GAP;
`else
  // No rate limiting: IDLE re-arbitrates the cycle right after the ack.
  localparam state_t S_POST = S_IDLE;
  logic gap_unused;
  assign gap_unused = |GAP_CYCLES;
`endif

  state_t            state;
  state_t            state_nxt;
  logic              take;
  logic              win;
  logic              done_ok;
  logic              done_tmo;
  logic              last_gnt;
  logic              mem_lat;
  logic [TMR_W-1:0]  tmr;
`ifdef DAC_RATE_LIMIT_EN
  logic [GAP_W-1:0]  gap_cnt;
`endif

  // Strobes are decoded straight from the one-cycle ISSUE state, so reset
  // removes them on the very next cycle and only one fires per command.
  assign dac_upd    = (state == S_ISSUE) && !mem_lat;
  assign dac_mem_wr = (state == S_ISSUE) &&  mem_lat;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode, arbitration and completion detection.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    win       = 1'b0;
    done_ok   = 1'b0;
    done_tmo  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          take      = 1'b1;
          // On a tie the port that did not win last time goes first.
          win       = (req0 && req1) ? ~last_gnt : req1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (dac_busy) begin
          state_nxt = S_WAIT_DONE;
        end else if (tmr == TMO_LAST) begin
          done_tmo  = 1'b1;
          state_nxt = S_POST;
        end
      end
      S_WAIT_DONE: begin
        if (!dac_busy) begin
          done_ok   = 1'b1;
          state_nxt = S_POST;
        end
      end
`ifdef DAC_RATE_LIMIT_EN
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Latch the winner's command at grant; it stays on the DAC bus until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_val  <= '0;
      dac_mode <= '0;
      mem_lat  <= 1'b0;
      grant    <= 1'b0;
      last_gnt <= 1'b1;
    end else if (take) begin
      dac_val  <= win ? val1  : val0;
      dac_mode <= win ? mode1 : mode0;
      mem_lat  <= win & mem1;
      grant    <= win;
      last_gnt <= win;
    end
  end

  // Completion pulses; cur_val only tracks commands the DAC actually accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err     <= 1'b0;
      cur_val <= '0;
    end else begin
      ack0 <= (done_ok || done_tmo) && !grant;
      ack1 <= (done_ok || done_tmo) &&  grant;
      err  <= done_tmo;
      if (done_ok) cur_val <= dac_val;
    end
  end

  // Busy-rise timer: counts cycles spent in WAIT_BUSY, zero everywhere else.
  always_ff @(posedge clk) begin
    if (rst)                       tmr <= '0;
    else if (state == S_WAIT_BUSY) tmr <= tmr + 1'b1;
    else                           tmr <= '0;
  end

`ifdef DAC_RATE_LIMIT_EN
  // Gap counter: counts cycles spent in GAP, zero everywhere else.
  always_ff @(posedge clk) begin
    if (rst)                 gap_cnt <= '0;
    else if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
    else                     gap_cnt <= '0;
  end
`endif

`ifndef SYNTHESIS
  // Completion signalling sanity checks.
  a_one_ack : assert property (@(posedge clk) disable iff (rst) !(ack0 && ack1));
  a_err_ack : assert property (@(posedge clk) disable iff (rst) err |-> (ack0 || ack1));
  a_one_stb : assert property (@(posedge clk) disable iff (rst) !(dac_upd && dac_mem_wr));
`endif

endmodule

// File: tb/tb_dac_cmd_scheduler.sv
// Self-checking bench for dac_cmd_scheduler: directed scenarios followed by
// randomized request traffic, checked against a transaction-level model.
`timescale 1ns/1ps
module tb_dac_cmd_scheduler;

  localparam int DATA_W     = 12;
  localparam int BUSY_TMO   = 40;
  localparam int GAP_CYCLES = 20;
`ifdef DAC_RATE_LIMIT_EN
  localparam int GAP = GAP_CYCLES;
`else
  localparam int GAP = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req0, req1, mem1, dac_busy;
  logic [DATA_W-1:0] val0, val1;
  logic [1:0]        mode0, mode1;
  logic              ack0, ack1, dac_upd, dac_mem_wr, grant, err;
  logic [DATA_W-1:0] dac_val, cur_val;
  logic [1:0]        dac_mode;

  always #5 clk = ~clk;

  dac_cmd_scheduler #(
    .DATA_W(DATA_W), .BUSY_TMO(BUSY_TMO), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .val0(val0), .mode0(mode0), .ack0(ack0),
    .req1(req1), .val1(val1), .mode1(mode1), .mem1(mem1), .ack1(ack1),
    .dac_val(dac_val), .dac_mode(dac_mode), .dac_upd(dac_upd),
    .dac_mem_wr(dac_mem_wr), .dac_busy(dac_busy), .grant(grant),
    .err(err), .cur_val(cur_val)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int tcnt    = 0;

  // Reference model state: pending requests, round-robin memory, last good code.
  bit                p [2];
  logic [DATA_W-1:0] pv [2];
  logic [1:0]        pm [2];
  bit                pmem;
  int                t_set;
  int                m_last;
  logic [DATA_W-1:0] m_cur;
  int                m_ack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    tcnt++;
  endtask

  function automatic logic [31:0] all_outs();
    return {ack0, ack1, err, dac_upd, dac_mem_wr, grant, dac_mode, dac_val, cur_val};
  endfunction

  task automatic drive_reqs();
    req0 = p[0]; val0 = pv[0]; mode0 = pm[0];
    req1 = p[1]; val1 = pv[1]; mode1 = pm[1]; mem1 = pmem;
  endtask

  task automatic set_req(input int port, input logic v);
    if (port == 0) req0 = v;
    else           req1 = v;
  endtask

  task automatic new_req(input int port);
    p[port]  = 1'b1;
    pv[port] = DATA_W'($urandom);
    pm[port] = 2'($urandom);
    if (port == 1) pmem = 1'($urandom);
  endtask

  task automatic launch();
    drive_reqs();
    t_set = tcnt;
  endtask

  task automatic model_reset();
    p[0] = 1'b0; p[1] = 1'b0;
    m_last = 1;
    m_cur  = '0;
    m_ack  = -1000;
  endtask

  // Serve one command end to end, predicting winner, strobe time and ack time.
  task automatic serve(input bit no_busy);
    int w, s_exp, s_tick, a_exp, a_tick, d, len;
    logic [DATA_W-1:0] ev;
    logic [1:0]        em;
    bit emem, extra, glitch;
    w     = (p[0] && p[1]) ? (1 - m_last) : (p[1] ? 1 : 0);
    ev    = pv[w];
    em    = pm[w];
    emem  = (w == 1) ? pmem : 1'b0;
    s_exp = t_set + 1;
    if (m_ack + 1 + GAP > s_exp) s_exp = m_ack + 1 + GAP;
    s_tick = -1;
    for (int i = 0; i < GAP + 6 && s_tick < 0; i++) begin
      tick();
      if (dac_upd || dac_mem_wr) s_tick = tcnt;
    end
    chk("strobe_tick", s_tick, s_exp);
    if (s_tick < 0) return;
    chk("grant", 32'(grant), w);
    chk("dac_val", 32'(dac_val), 32'(ev));
    chk("dac_mode", 32'(dac_mode), 32'(em));
    chk("strobe_kind", {dac_mem_wr, dac_upd}, emem ? 2'b10 : 2'b01);
    chk("no_ack_at_strobe", {ack0, ack1, err}, 3'b000);
    m_last = w;
    // Change the winner's inputs after grant; the latched command must not follow.
    pv[w] = DATA_W'($urandom);
    pm[w] = 2'($urandom);
    if (w == 1) pmem = 1'($urandom);
    drive_reqs();
    glitch = !p[1-w] && ($urandom_range(0, 1) == 1);
    extra  = 1'b0;
    if (!no_busy) begin
      d   = $urandom_range(2, 8);
      len = $urandom_range(1, 6);
      for (int i = 0; i < d; i++) begin
        tick();
        extra |= dac_upd | dac_mem_wr | ack0 | ack1 | err;
        if (glitch && i == 0) set_req(1 - w, 1'b1);
        if (glitch && i == 1) set_req(1 - w, 1'b0);
      end
      dac_busy = 1'b1;
      for (int i = 0; i < len; i++) begin
        tick();
        extra |= dac_upd | dac_mem_wr | ack0 | ack1 | err;
      end
      dac_busy = 1'b0;
      tick();
      chk("quiet_in_flight", extra, 0);
      chk("ack_pair", {ack0, ack1}, (w == 0) ? 2'b10 : 2'b01);
      chk("err_clear", err, 0);
      chk("cur_val", 32'(cur_val), 32'(ev));
      chk("dac_val_held", {dac_mode, dac_val}, {em, ev});
      m_cur = ev;
    end else begin
      a_exp  = s_tick + 1 + BUSY_TMO;
      a_tick = -1;
      for (int i = 0; i < BUSY_TMO + 6 && a_tick < 0; i++) begin
        tick();
        if (ack0 || ack1) a_tick = tcnt;
        else extra |= dac_upd | dac_mem_wr | err;
        if (glitch && i == 0) set_req(1 - w, 1'b1);
        if (glitch && i == 1) set_req(1 - w, 1'b0);
      end
      chk("quiet_in_flight", extra, 0);
      chk("tmo_tick", a_tick, a_exp);
      chk("tmo_ack_pair", {ack0, ack1}, (w == 0) ? 2'b10 : 2'b01);
      chk("tmo_err", err, 1);
      chk("tmo_cur_val", 32'(cur_val), 32'(m_cur));
    end
    m_ack = tcnt;
    p[w]  = 1'b0;
    drive_reqs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idle, r;
    bit q;
    rst = 1'b1; dac_busy = 1'b0; pmem = 1'b0;
    pv[0] = '0; pv[1] = '0; pm[0] = '0; pm[1] = '0;
    model_reset();
    drive_reqs();
    tick(); tick(); tick();
    chk("reset_outs", all_outs(), 0);
    rst = 1'b0;

    // Single stream write of mid-scale.
    new_req(0); pv[0] = 12'h800; pm[0] = 2'b00;
    launch(); serve(1'b0);
    chk("t1_grant", grant, 0);
    chk("t1_cur_val", 32'(cur_val), 32'h800);

    // EEPROM write from the config port.
    new_req(1); pv[1] = 12'hABC; pm[1] = 2'b01; pmem = 1'b1;
    launch(); serve(1'b0);

    // Busy never rises.
    new_req(0);
    launch(); serve(1'b1);

    // Reset while waiting for busy to fall.
    new_req(0);
    launch();
    tick();
    chk("t5_strobe", dac_upd, 1);
    dac_busy = 1'b1;
    tick(); tick();
    rst = 1'b1; dac_busy = 1'b0;
    p[0] = 1'b0; drive_reqs();
    tick();
    chk("t5_outs_zero", all_outs(), 0);
    rst = 1'b0;
    q = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      q |= ack0 | ack1 | err | dac_upd | dac_mem_wr;
    end
    chk("t5_no_ack", q, 0);
    model_reset();

    // Simultaneous requests after reset, then repeat to see alternation.
    new_req(0); new_req(1);
    launch(); serve(1'b0);
    chk("t2_first", grant, 0);
    launch(); serve(1'b0);
    chk("t2_second", grant, 1);
    new_req(0); new_req(1);
    launch(); serve(1'b0);
    chk("t2_third", grant, 0);
    launch(); serve(1'b0);

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      if (!p[0] && !p[1]) begin
        idle = $urandom_range(0, 3);
        q = 1'b0;
        for (int i = 0; i < idle; i++) begin
          tick();
          q |= dac_upd | dac_mem_wr | ack0 | ack1 | err;
        end
        if (idle > 0) chk("idle_quiet", q, 0);
        r = $urandom_range(1, 3);
        if ((r & 1) != 0) new_req(0);
        if ((r & 2) != 0) new_req(1);
      end else if ($urandom_range(0, 1) == 1) begin
        new_req(p[0] ? 1 : 0);
      end
      launch();
      serve($urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
